// File: rtl/tp_rtype_pkg.sv
// Shared encodings for the multi-channel transpose custom-instruction dispatcher.
package tp_rtype_pkg;

    localparam logic [6:0]  OPC_RTYPE       = 7'h33;
    localparam logic [3:0]  F7_TP_BASE      = 4'b0001;
    localparam logic [31:0] TP_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        F3_AWR   = 3'b000,
        F3_START = 3'b001,
        F3_STAT  = 3'b010,
        F3_BRD   = 3'b011,
        F3_WAIT  = 3'b100,
        F3_CLR   = 3'b101,
        F3_IRQEN = 3'b110,
        F3_RSVD  = 3'b111
    } tp_funct3_e;

    localparam int STAT_DONE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_BOUNDS  = 2;
    localparam int STAT_REJECT  = 3;
    localparam int STAT_TIMEOUT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BRD  = 2'd1,
        S_WAIT = 2'd2
    } tp_state_e;

    function automatic logic [31:0] stat_word(input logic [4:0] status);
        return {27'b0, status};
    endfunction

endpackage

// File: rtl/tp_rtype_dispatch_mc_status.sv
// Per-channel sticky done/error flags and interrupt enable.
module tp_chan_status
    import tp_rtype_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_busy,
    input  logic       i_done_set,
    input  logic       i_done_clr,
    input  logic       i_err_clr,
    input  logic       i_bounds_set,
    input  logic       i_reject_set,
    input  logic       i_timeout_set,
    input  logic       i_irq_en_we,
    input  logic       i_irq_en_val,
    output logic [4:0] o_status,
    output logic       o_irq
);

    logic r_done;
    logic r_bounds;
    logic r_reject;
    logic r_timeout;
    logic r_irq_en;

    // Set always wins over clear so an event landing with a clear is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_bounds  <= 1'b0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;
            r_irq_en  <= 1'b0;
        end else begin
            if (i_done_set)         r_done <= 1'b1;
            else if (i_done_clr)    r_done <= 1'b0;

            if (i_bounds_set)       r_bounds <= 1'b1;
            else if (i_err_clr)     r_bounds <= 1'b0;

            if (i_reject_set)       r_reject <= 1'b1;
            else if (i_err_clr)     r_reject <= 1'b0;

            if (i_timeout_set)      r_timeout <= 1'b1;
            else if (i_err_clr)     r_timeout <= 1'b0;

            if (i_irq_en_we)        r_irq_en <= i_irq_en_val;
        end
    end

    always_comb begin
        o_status               = '0;
        o_status[STAT_DONE]    = r_done;
        o_status[STAT_BUSY]    = i_busy;
        o_status[STAT_BOUNDS]  = r_bounds;
        o_status[STAT_REJECT]  = r_reject;
        o_status[STAT_TIMEOUT] = r_timeout;
    end

    assign o_irq = r_done & r_irq_en;

endmodule

// File: rtl/tp_rtype_dispatch_mc.sv
// Decodes TP-class R-type custom instructions and steers them to NCH transpose engines.
//   state  | meaning
//   S_IDLE | accepting instructions, single-cycle ops complete here
//   S_BRD  | waiting for b_rvalid of the held channel, or timeout
//   S_WAIT | waiting for done of the held channel, or timeout
module tp_rtype_dispatch_mc
    import tp_rtype_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int NROWS   = 8,
    parameter int NCOLS   = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    input  logic [31:0]           rs1_val,
    input  logic [31:0]           rs2_val,
    input  logic [4:0]            rd_addr,
    output logic                  rd_we,
    output logic [4:0]            rd_waddr,
    output logic [31:0]           rd_wdata,
    output logic                  illegal,
    output logic                  irq,
    output logic [NCH-1:0]        tp_start,
    input  logic [NCH-1:0]        tp_busy,
    input  logic [NCH-1:0]        tp_done,
    output logic [NCH-1:0]        a_we,
    output logic [31:0]           a_row,
    output logic [31:0]           a_col,
    output logic [DATA_W-1:0]     a_wdata,
    output logic [NCH-1:0]        b_re,
    output logic [31:0]           b_row,
    output logic [31:0]           b_col,
    input  logic [NCH*DATA_W-1:0] b_rdata,
    input  logic [NCH-1:0]        b_rvalid
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    tp_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_rd_hold;
    logic [2:0]       r_ch_hold;

    tp_funct3_e  w_f3;
    logic [6:0]  w_f7;
    logic [2:0]  w_ch;
    logic [15:0] w_row;
    logic [15:0] w_col;
    logic        w_tp;
    logic        w_accept;
    logic        w_ch_ok;
    logic        w_legal;
    logic        w_inb;
    logic        w_cnt_hit;
    logic        w_unused;

    logic [4:0]  w_status [NCH];
    logic [NCH-1:0] w_irq;
    logic [NCH-1:0] w_sel;
    logic [NCH-1:0] w_hold_sel;

    logic [4:0]  w_stat_ch;
    logic [4:0]  w_stat_hold;
    logic [4:0]  w_wait_word;
    logic [4:0]  w_tmo_word;
    logic [31:0] w_rdata_ext;
    logic        w_rvalid_hold;
    logic        w_tpdone_hold;

    logic        w_brd_ok;
    logic        w_brd_tmo;
    logic        w_wait_ok;
    logic        w_wait_tmo;

    assign w_f7     = instr[31:25];
    assign w_f3     = tp_funct3_e'(instr[14:12]);
    assign w_ch     = w_f7[2:0];
    assign w_row    = rs1_val[31:16];
    assign w_col    = rs1_val[15:0];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    assign instr_ready = (r_state == S_IDLE);

    assign w_tp     = (instr[6:0] == OPC_RTYPE) && (w_f7[6:3] == F7_TP_BASE);
    assign w_accept = instr_valid & instr_ready & w_tp & ~rst;
    assign w_ch_ok  = ({29'b0, w_ch} < NCH);
    assign w_legal  = w_accept & w_ch_ok & (w_f3 != F3_RSVD);
    assign illegal  = w_accept & ~w_legal;
    assign w_inb    = ({16'b0, w_row} < NROWS) && ({16'b0, w_col} < NCOLS);

    assign a_row   = {16'b0, w_row};
    assign a_col   = {16'b0, w_col};
    assign b_row   = {16'b0, w_row};
    assign b_col   = {16'b0, w_col};
    assign a_wdata = rs2_val[DATA_W-1:0];

    assign w_cnt_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        w_stat_ch     = '0;
        w_stat_hold   = '0;
        w_rdata_ext   = '0;
        w_rvalid_hold = 1'b0;
        w_tpdone_hold = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (w_ch == 3'(c)) w_stat_ch = w_status[c];
            if (r_ch_hold == 3'(c)) begin
                w_stat_hold                = w_status[c];
                w_rdata_ext[DATA_W-1:0]    = b_rdata[c*DATA_W +: DATA_W];
                w_rvalid_hold              = b_rvalid[c];
                w_tpdone_hold              = tp_done[c];
            end
        end
    end

    assign w_brd_ok   = (r_state == S_BRD)  & ~rst & w_rvalid_hold;
    assign w_brd_tmo  = (r_state == S_BRD)  & ~rst & ~w_rvalid_hold & w_cnt_hit;
    assign w_wait_ok  = (r_state == S_WAIT) & ~rst & (w_stat_hold[STAT_DONE] | w_tpdone_hold);
    assign w_wait_tmo = (r_state == S_WAIT) & ~rst & ~w_stat_hold[STAT_DONE] & ~w_tpdone_hold
                        & w_cnt_hit;

    always_comb begin
        w_wait_word               = w_stat_hold;
        w_wait_word[STAT_DONE]    = 1'b1;
        w_tmo_word                = w_stat_hold;
        w_tmo_word[STAT_TIMEOUT]  = 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            logic w_done_set;
            logic w_done_clr;

            assign w_sel[g]      = w_legal && (w_ch == 3'(g));
            assign w_hold_sel[g] = (r_ch_hold == 3'(g));

            assign a_we[g]     = w_sel[g] & (w_f3 == F3_AWR) & w_inb;
            assign tp_start[g] = w_sel[g] & (w_f3 == F3_START) & ~tp_busy[g];
            assign b_re[g]     = w_sel[g] & (w_f3 == F3_BRD) & w_inb;

            // A WAIT that completes on the live done pulse consumes it, so it must not re-arm the sticky bit.
            assign w_done_set = tp_done[g] & ~(w_wait_ok & w_hold_sel[g]);
            assign w_done_clr = (w_sel[g] & (((w_f3 == F3_START) & ~tp_busy[g])
                                           | ((w_f3 == F3_WAIT) & w_status[g][STAT_DONE])
                                           |  (w_f3 == F3_CLR)))
                              | (w_wait_ok & w_hold_sel[g]);

            tp_chan_status u_status (
                .clk           (clk),
                .rst           (rst),
                .i_busy        (tp_busy[g]),
                .i_done_set    (w_done_set),
                .i_done_clr    (w_done_clr),
                .i_err_clr     (w_sel[g] & (w_f3 == F3_CLR)),
                .i_bounds_set  (w_sel[g] & ((w_f3 == F3_AWR) | (w_f3 == F3_BRD)) & ~w_inb),
                .i_reject_set  (w_sel[g] & (w_f3 == F3_START) & tp_busy[g]),
                .i_timeout_set (w_hold_sel[g] & (w_brd_tmo | w_wait_tmo)),
                .i_irq_en_we   (w_sel[g] & (w_f3 == F3_IRQEN)),
                .i_irq_en_val  (rs2_val[0]),
                .o_status      (w_status[g]),
                .o_irq         (w_irq[g])
            );
        end
    endgenerate

    assign irq = |w_irq;

    always_comb begin
        rd_we    = 1'b0;
        rd_wdata = '0;
        rd_waddr = (r_state == S_IDLE) ? rd_addr : r_rd_hold;
        if (w_brd_ok) begin
            rd_we    = 1'b1;
            rd_wdata = w_rdata_ext;
        end else if (w_brd_tmo) begin
            rd_we    = 1'b1;
            rd_wdata = TP_TIMEOUT_DATA;
        end else if (w_wait_ok) begin
            rd_we    = 1'b1;
            rd_wdata = stat_word(w_wait_word);
        end else if (w_wait_tmo) begin
            rd_we    = 1'b1;
            rd_wdata = stat_word(w_tmo_word);
        end else if (w_legal) begin
            case (w_f3)
                F3_STAT: begin
                    rd_we    = 1'b1;
                    rd_wdata = stat_word(w_stat_ch);
                end
                F3_BRD: begin
                    rd_we    = ~w_inb;
                    rd_wdata = '0;
                end
                F3_WAIT: begin
                    rd_we    = w_stat_ch[STAT_DONE];
                    rd_wdata = stat_word(w_stat_ch);
                end
                default: begin
                    rd_we    = 1'b0;
                    rd_wdata = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_hold <= '0;
            r_ch_hold <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_legal && (w_f3 == F3_BRD) && w_inb) begin
                        r_state   <= S_BRD;
                        r_cnt     <= '0;
                        r_rd_hold <= rd_addr;
                        r_ch_hold <= w_ch;
                    end else if (w_legal && (w_f3 == F3_WAIT) && !w_stat_ch[STAT_DONE]) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= '0;
                        r_rd_hold <= rd_addr;
                        r_ch_hold <= w_ch;
                    end
                end
                S_BRD: begin
                    if (w_brd_ok || w_brd_tmo) r_state <= S_IDLE;
                    else                       r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_WAIT: begin
                    if (w_wait_ok || w_wait_tmo) r_state <= S_IDLE;
                    else                         r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tp_rtype_dispatch_mc.sv
// Bench for tp_rtype_dispatch_mc: writebacks go through a scoreboard, strobes are checked inline.
module tb_tp_rtype_dispatch_mc;

    localparam int NCH     = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] F_AWR   = 3'b000;
    localparam logic [2:0] F_START = 3'b001;
    localparam logic [2:0] F_STAT  = 3'b010;
    localparam logic [2:0] F_BRD   = 3'b011;
    localparam logic [2:0] F_WAIT  = 3'b100;
    localparam logic [2:0] F_CLR   = 3'b101;
    localparam logic [2:0] F_IRQEN = 3'b110;
    localparam logic [2:0] F_RSVD  = 3'b111;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [31:0]           rs1_val;
    logic [31:0]           rs2_val;
    logic [4:0]            rd_addr;
    logic                  rd_we;
    logic [4:0]            rd_waddr;
    logic [31:0]           rd_wdata;
    logic                  illegal;
    logic                  irq;
    logic [NCH-1:0]        tp_start;
    logic [NCH-1:0]        tp_busy;
    logic [NCH-1:0]        tp_done;
    logic [NCH-1:0]        a_we;
    logic [31:0]           a_row;
    logic [31:0]           a_col;
    logic [DATA_W-1:0]     a_wdata;
    logic [NCH-1:0]        b_re;
    logic [31:0]           b_row;
    logic [31:0]           b_col;
    logic [NCH*DATA_W-1:0] b_rdata;
    logic [NCH-1:0]        b_rvalid;

    int checks = 0;
    int errors = 0;
    logic [4:0]  exp_addr [$];
    logic [31:0] exp_data [$];

    always #5 clk = ~clk;

    tp_rtype_dispatch_mc #(
        .NCH(NCH), .NROWS(8), .NCOLS(8), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .illegal(illegal), .irq(irq),
        .tp_start(tp_start), .tp_busy(tp_busy), .tp_done(tp_done),
        .a_we(a_we), .a_row(a_row), .a_col(a_col), .a_wdata(a_wdata),
        .b_re(b_re), .b_row(b_row), .b_col(b_col),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid)
    );

    // Writeback monitor: samples 3 time units after each falling edge.
    always @(negedge clk) begin
        #3;
        if (rd_we === 1'b1) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb: got addr=%0d data=%08h, required no writeback",
                         rd_waddr, rd_wdata);
            end else begin
                logic [4:0]  ea;
                logic [31:0] ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (rd_waddr !== ea || rd_wdata !== ed) begin
                    errors++;
                    $display("FAIL wb: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             rd_waddr, rd_wdata, ea, ed);
                end
            end
        end
    end

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [4:0] rd);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {f7, 10'd0, f3, 5'd0, 7'h33};
        rs1_val     = rs1;
        rs2_val     = rs2;
        rd_addr     = rd;
        tp_done     = '0;
        b_rvalid    = '0;
    endtask

    task automatic idle();
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        tp_done     = '0;
        b_rvalid    = '0;
    endtask

    function automatic logic [6:0] f7ch(input int ch);
        return 7'h08 | 7'(ch);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        tp_busy = '0; tp_done = '0; b_rdata = '0; b_rvalid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({instr_ready, rd_we, illegal, irq, tp_start, a_we, b_re} !== {4'b1000, 12'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required %b",
                     {instr_ready, rd_we, illegal, irq, tp_start, a_we, b_re}, {4'b1000, 12'b0});
        end
        send(f7ch(0), F_STAT, 32'h0, 32'h0, 5'd5);
        expect_wb(5'd5, 32'h0);
        idle();
    endtask

    task automatic test_awr();
        send(f7ch(2), F_AWR, {16'd1, 16'd3}, 32'h1234, 5'd0);
        #1;
        checks++;
        if (a_we !== 4'b0100 || a_row !== 32'd1 || a_col !== 32'd3 || a_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL awr_strobe: got we=%b row=%0d col=%0d data=%h, required we=0100 row=1 col=3 data=1234",
                     a_we, a_row, a_col, a_wdata);
        end
        idle();
        #1;
        checks++;
        if (a_we !== 4'b0000) begin
            errors++;
            $display("FAIL awr_one_cycle: got %b, required 0000", a_we);
        end
        send(f7ch(2), F_AWR, {16'd8, 16'd3}, 32'h1234, 5'd0);
        #1;
        checks++;
        if (a_we !== 4'b0000) begin
            errors++;
            $display("FAIL awr_oob: got %b, required 0000", a_we);
        end
        send(f7ch(2), F_STAT, 32'h0, 32'h0, 5'd7);
        expect_wb(5'd7, 32'h4);
        idle();
    endtask

    task automatic test_wait();
        send(f7ch(1), F_START, 32'h0, 32'h0, 5'd0);
        #1;
        checks++;
        if (tp_start !== 4'b0010) begin
            errors++;
            $display("FAIL start_pulse: got %b, required 0010", tp_start);
        end
        send(f7ch(1), F_WAIT, 32'h0, 32'h0, 5'd9);
        tp_busy = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            idle();
            #1;
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_stall: got ready=%b, required 0", instr_ready);
            end
        end
        idle();
        tp_busy = 4'b0000;
        tp_done = 4'b0010;
        expect_wb(5'd9, 32'h1);
        idle();
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_release: got ready=%b, required 1", instr_ready);
        end
        send(f7ch(1), F_STAT, 32'h0, 32'h0, 5'd10);
        expect_wb(5'd10, 32'h0);
        idle();
    endtask

    task automatic test_brd();
        int n;
        send(f7ch(3), F_BRD, {16'd2, 16'd5}, 32'h0, 5'd12);
        #1;
        checks++;
        if (b_re !== 4'b1000 || b_row !== 32'd2 || b_col !== 32'd5) begin
            errors++;
            $display("FAIL brd_strobe: got re=%b row=%0d col=%0d, required re=1000 row=2 col=5",
                     b_re, b_row, b_col);
        end
        idle();
        rd_addr = 5'd3;
        b_rvalid = 4'b0001;
        b_rdata[0 +: DATA_W] = 32'h1111;
        idle();
        b_rvalid = 4'b0001;
        idle();
        b_rvalid = 4'b1000;
        b_rdata[3*DATA_W +: DATA_W] = 32'h0000CAFE;
        expect_wb(5'd12, 32'h0000CAFE);
        idle();
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL brd_release: got ready=%b, required 1", instr_ready);
        end

        send(f7ch(3), F_BRD, {16'd0, 16'd0}, 32'h0, 5'd13);
        expect_wb(5'd13, 32'hDEADBEEF);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            #2;
            n++;
            if (rd_we === 1'b1) break;
        end
        checks++;
        if (n != TIMEOUT + 1 || rd_we !== 1'b1) begin
            errors++;
            $display("FAIL brd_timeout_latency: got %0d cycles (rd_we=%b), required %0d",
                     n, rd_we, TIMEOUT + 1);
        end
        send(f7ch(3), F_STAT, 32'h0, 32'h0, 5'd14);
        expect_wb(5'd14, 32'h10);
        send(f7ch(3), F_BRD, {16'd0, 16'd8}, 32'h0, 5'd15);
        expect_wb(5'd15, 32'h0);
        #1;
        checks++;
        if (b_re !== 4'b0000 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL brd_oob: got re=%b ready=%b, required re=0000 ready=1", b_re, instr_ready);
        end
        send(f7ch(3), F_STAT, 32'h0, 32'h0, 5'd16);
        expect_wb(5'd16, 32'h14);
        idle();
    endtask

    task automatic test_reject_irq();
        send(f7ch(0), F_START, 32'h0, 32'h0, 5'd0);
        tp_busy = 4'b0001;
        #1;
        checks++;
        if (tp_start !== 4'b0000) begin
            errors++;
            $display("FAIL start_reject: got %b, required 0000", tp_start);
        end
        idle();
        tp_busy = 4'b0000;
        send(f7ch(0), F_STAT, 32'h0, 32'h0, 5'd1);
        expect_wb(5'd1, 32'h8);
        send(f7ch(0), F_IRQEN, 32'h0, 32'h1, 5'd0);
        idle();
        tp_done = 4'b0001;
        idle();
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b, required 1", irq);
        end
        send(f7ch(0), F_CLR, 32'h0, 32'h0, 5'd0);
        idle();
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr: got %b, required 0", irq);
        end
        send(f7ch(0), F_STAT, 32'h0, 32'h0, 5'd2);
        expect_wb(5'd2, 32'h0);
        send(f7ch(0), F_CLR, 32'h0, 32'h0, 5'd0);
        tp_done = 4'b0001;
        idle();
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL done_beats_clr: got irq=%b, required 1", irq);
        end
        send(f7ch(0), F_STAT, 32'h0, 32'h0, 5'd3);
        expect_wb(5'd3, 32'h1);
        send(f7ch(0), F_WAIT, 32'h0, 32'h0, 5'd20);
        expect_wb(5'd20, 32'h1);
        idle();
        #1;
        checks++;
        if (instr_ready !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL wait_immediate: got ready=%b irq=%b, required ready=1 irq=0",
                     instr_ready, irq);
        end
        tp_done = 4'b0001;
        idle();
    endtask

    task automatic test_rst_mid();
        send(f7ch(2), F_BRD, {16'd1, 16'd1}, 32'h0, 5'd21);
        #1;
        checks++;
        if (b_re !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_brd: got re=%b, required 0100", b_re);
        end
        idle();
        rst = 1'b1;
        b_rvalid = 4'b0100;
        b_rdata[2*DATA_W +: DATA_W] = 32'h55;
        #1;
        checks++;
        if (rd_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wb: got rd_we=%b, required 0", rd_we);
        end
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1 || irq !== 1'b0 || rd_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got ready=%b irq=%b we=%b, required 1 0 0",
                     instr_ready, irq, rd_we);
        end
        send(f7ch(0), F_STAT, 32'h0, 32'h0, 5'd22);
        expect_wb(5'd22, 32'h0);
        idle();
    endtask

    task automatic test_illegal();
        send(7'h0F, F_AWR, {16'd1, 16'd1}, 32'h0, 5'd0);
        #1;
        checks++;
        if (illegal !== 1'b1 || a_we !== 4'b0 || tp_start !== 4'b0 || b_re !== 4'b0) begin
            errors++;
            $display("FAIL illegal_ch: got ill=%b we=%b st=%b re=%b, required 1 0000 0000 0000",
                     illegal, a_we, tp_start, b_re);
        end
        send(7'h0F, F_STAT, 32'h0, 32'h0, 5'd23);
        send(f7ch(0), F_RSVD, 32'h0, 32'h0, 5'd0);
        #1;
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_f3: got %b, required 1", illegal);
        end
        send(7'h00, F_AWR, {16'd1, 16'd1}, 32'h0, 5'd0);
        #1;
        checks++;
        if (illegal !== 1'b0 || a_we !== 4'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL non_tp: got ill=%b we=%b ready=%b, required 0 0000 1",
                     illegal, a_we, instr_ready);
        end
        idle();
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: got %b, required 0", illegal);
        end
    endtask

    initial begin
        test_reset();
        test_awr();
        test_wait();
        test_brd();
        test_reject_irq();
        test_rst_mid();
        test_illegal();
        repeat (3) idle();
        checks++;
        if (exp_addr.size() != 0) begin
            errors++;
            $display("FAIL missing_wb: got %0d writebacks outstanding, required 0", exp_addr.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tp_rtype_dispatch_mc.md
Name: tp_rtype_dispatch_mc

Overview:
Multi-channel successor to the single-engine transpose custom-instruction wrapper. It decodes RV32 R-type custom instructions and steers them to one of NCH transpose engines. It adds per-channel sticky done/error status, a blocking WAIT instruction, per-channel interrupt enables, bounds checking, and a read-timeout recovery. It sits between the CPU custom-instruction port and an array of top_transpose_cpu-style engines.

Parameters:
NCH, 4, number of transpose engines (1..8)
NROWS, 8, matrix rows per engine; row index must be < NROWS
NCOLS, 8, matrix cols per engine; col index must be < NCOLS
DATA_W, 32, element width (<=32)
TIMEOUT, 1024, max stall cycles for BRD/WAIT; 0 = never time out

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  CPU offers instruction
instr_ready  out  1  dispatcher can accept
instr  in  32  instruction word
rs1_val  in  32  {row[31:16], col[15:0]}
rs2_val  in  32  write data / IRQEN value
rd_addr  in  5  destination register
rd_we  out  1  register writeback strobe
rd_waddr  out  5  writeback register
rd_wdata  out  32  writeback data
illegal  out  1  1-cycle pulse: accepted TP-class instr with bad channel or funct3=111
irq  out  1  OR over channels of (done_sticky & irq_en)
tp_start  out  NCH  per-channel start pulse
tp_busy  in  NCH  per-channel busy level
tp_done  in  NCH  per-channel done pulse
a_we  out  NCH  per-channel A write strobe
a_row, a_col  out  32 each  shared A address
a_wdata  out  DATA_W  shared A data
b_re  out  NCH  per-channel B read strobe
b_row, b_col  out  32 each  shared B address
b_rdata  in  NCH*DATA_W  per-channel B data, channel c at [c*DATA_W +: DATA_W]
b_rvalid  in  NCH  per-channel B data valid

Behaviour:
- Decode: TP-class when opcode==0x33 and funct7[6:3]==4'b0001. ch=funct7[2:0]; ch>=NCH is illegal. Non-TP instructions: ignored, no side effects; ready unaffected.
- accept = instr_valid & instr_ready & TP-class. instr_ready = (state==S_IDLE).
- funct3 000 AWR: a_we[ch] pulses in the accept cycle. If out of bounds, no strobe and bounds_err set.
- funct3 001 START: if tp_busy[ch]==0, tp_start[ch] pulses and done_sticky[ch] clears. If busy, no pulse and reject_err set.
- funct3 010 STAT: same-cycle rd_we. rd_wdata = {27'b0, timeout_err, reject_err, bounds_err, busy, done_sticky}. No clearing.
- funct3 011 BRD: in bounds → b_re[ch] pulse, latch rd_addr/ch, go to S_BRD. Out of bounds → same-cycle rd_we with 0 and bounds_err set; stay in S_IDLE.
- funct3 100 WAIT: if done_sticky[ch] is already set, same-cycle rd_we with STAT word and clear done_sticky. Otherwise latch rd_addr/ch and go to S_WAIT.
- funct3 101 CLR: clears done_sticky and all three error bits of ch.
- funct3 110 IRQEN: irq_en[ch] <= rs2_val[0].
- funct3 111: illegal pulse, no other effect. Illegal-channel instructions likewise only pulse illegal.
- S_BRD:
  - b_rvalid[ch_hold] → rd_we, rd_waddr=rd_hold, rd_wdata=zero-extended b_rdata slice; go to S_IDLE.
  - Counter reaches TIMEOUT first → rd_wdata=32'hDEADBEEF, timeout_err set, go to S_IDLE.
  - rvalid on other channels or while in S_IDLE is ignored.
- S_WAIT:
  - done_sticky[ch_hold] or tp_done[ch_hold] → rd_we with STAT word (done bit=1), clear done_sticky, go to S_IDLE.
  - On timeout → STAT word with timeout_err set, go to S_IDLE.
- Stall counter: clears on entry to S_BRD/S_WAIT and increments each stalled cycle. Its width is clog2(TIMEOUT+1).
- Sticky update priority per channel: tp_done set beats START/CLR/WAIT clear in the same cycle. Error-set beats CLR in the same cycle.
- Reset (any time, including mid-stall): state=S_IDLE; all sticky bits, irq_en, counter, rd_hold, ch_hold = 0. Outputs: rd_we=0, illegal=0, irq=0, tp_start/a_we/b_re=0, instr_ready=1 the cycle after reset. A pending BRD/WAIT is abandoned with no writeback.
- Default bus values: a_row/b_row=rs1[31:16], a_col/b_col=rs1[15:0], a_wdata=rs2_val[DATA_W-1:0], rd_waddr=rd_addr except in stall writeback.

Decomposition:
- Package tp_rtype_pkg holds:
  - OPC_RTYPE, F7_TP_BASE, funct3 enum
  - STAT bit-position constants, TP_TIMEOUT_DATA=32'hDEADBEEF
  - state enum {S_IDLE,S_BRD,S_WAIT}
- Sub-module tp_chan_status, instantiated NCH times. It holds done_sticky, three error bits, irq_en and the set/clear priority logic, and outputs a 5-bit status plus an irq bit.

Test Plan:
- Reset, then STAT ch0 (instr funct7=0x08, funct3=010) → same-cycle rd_we, rd_wdata=0x0.
- AWR ch2 row=1 col=3 data=0x1234 → a_we=4'b0100 for one cycle, a_row=1, a_col=3. Repeat with row=8 → no a_we; STAT ch2 returns bit2=1.
- START ch1, engine busy 5 cycles, then tp_done pulse; WAIT ch1 issued while busy → instr_ready low until done, then rd_wdata=0x1. A following STAT returns 0x0.
- BRD ch3 with b_rvalid after 3 cycles, b_rdata slice=0xCAFE → rd_we once with rd_waddr=latched rd, data 0xCAFE. With TIMEOUT=16 and no rvalid → 0xDEADBEEF after 16 stall cycles; STAT bit4=1.
- START ch0 while tp_busy[0]=1 → no tp_start, reject_err set. IRQEN ch0=1 then tp_done[0] → irq=1; CLR → irq=0. tp_done coinciding with CLR → done stays 1.
- Assert rst during S_BRD → no rd_we, instr_ready=1 next cycle. funct7=0x0F with NCH=4 → illegal pulse, no strobes.
